sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_ctrl_pkg.sv | 15 +
 rtl/sram_wait_counter.sv | 36 +++
 rtl/sram_controller.sv | 116 +++++++++++
 tb/tb_sram_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: state encoding, data width and
// default address-map parameters.
package sram_ctrl_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned DEF_SRAM_AW   = 17;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// ACCESS-phase timer: cleared by load_i, advances while count_i is high and
// flags done_o on its final count (WAIT_CYCLES-1).
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (count_i && !done_o) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Multi-cycle SRAM controller that stalls the memory stage via ready.
// Optional address checking (addr_err port) is enabled by SRAM_CTRL_ADDR_CHECK_EN.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    output logic               addr_err,
`endif
    inout  wire  [DATA_W-1:0]  SRAM_DQ
);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [SRAM_AW-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                req;
    logic                req_err;
    logic                cnt_done;
    logic                drive;

    assign req = wr_en | rd_en;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    assign req_err = (address < BASE_ADDR) || (address[1:0] != 2'b00) ||
                     (((address - BASE_ADDR) >> (SRAM_AW + 2)) != 32'd0);
`else
    assign req_err = 1'b0;
`endif

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk_i   (CLK),
        .rst_i   (RST),
        .load_i  (state_q != ACCESS),
        .count_i (state_q == ACCESS),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    wr_d    = wr_en;
                    err_d   = req_err;
                    addr_d  = SRAM_AW'((address - BASE_ADDR) >> 2);
                    wdata_d = writeData;
                end
            end
            ACCESS: begin
                if (cnt_done) begin
                    state_d = DONE;
                    // Sample the bus on the edge that closes the last access cycle.
                    if (!wr_q && !err_q) begin
                        rdata_d = SRAM_DQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge CLK) begin
        wdata_q <= wdata_d;
    end

    assign drive     = (state_q == ACCESS) && wr_q && !err_q;
    assign SRAM_WE_N = !drive;
    assign SRAM_DQ   = drive ? wdata_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign readData  = rdata_q;
    assign ready     = ((state_q == IDLE) && !req) || (state_q == DONE);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    assign addr_err = (state_q == DONE) && err_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed and randomized bench for sram_controller with a behavioural SRAM
// and a word-indexed reference memory.
module tb_sram_controller;

    localparam int          W    = 5;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          AW   = 17;

    logic          CLK = 1'b0;
    logic          RST;
    logic          wr_en, rd_en;
    logic [31:0]   address, writeData;
    logic [31:0]   readData;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic          we_n;
    wire  [31:0]   SRAM_DQ;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
    logic          addr_err;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic [31:0]   sram_mem [0:(1<<AW)-1];
    logic [31:0]   ref_mem  [int unsigned];
    logic [31:0]   exp_rd;

    sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .ready     (ready),
        .SRAM_ADDR (sram_addr),
        .SRAM_WE_N (we_n),
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        .addr_err  (addr_err),
`endif
        .SRAM_DQ   (SRAM_DQ)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Asynchronous-read SRAM that drives the bus whenever it is not being written.
    assign SRAM_DQ = we_n ? sram_mem[sram_addr] : 32'bz;
    always @(posedge CLK) if (!we_n) sram_mem[sram_addr] <= SRAM_DQ;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic int unsigned word_idx(input logic [31:0] a);
        return ((a - BASE) / 4) % (1 << AW);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic finish_idle(input string tag);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge CLK); #1;
        check({tag, "_idle_rdy"}, {31'd0, ready}, 32'd1);
        check({tag, "_hold_rd"}, readData, exp_rd);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        check({tag, "_idle_err"}, {31'd0, addr_err}, 32'd0);
`endif
    endtask

    task automatic issue(input bit from_done, input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
        int unsigned idx;
        wr_en = w; rd_en = r; address = a; writeData = d;
        if (from_done) begin
            @(posedge CLK); #1;
        end else begin
            #1;
        end
        idx = word_idx(a);
        check({tag, "_rdy0"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge CLK); #1;
            check({tag, "_acc_rdy"}, {31'd0, ready}, 32'd0);
            check({tag, "_we_n"}, {31'd0, we_n}, w ? 32'd0 : 32'd1);
            if (i == 1) check({tag, "_addr"}, 32'(sram_addr), idx);
        end
        @(posedge CLK); #1;
        check({tag, "_done_rdy"}, {31'd0, ready}, 32'd1);
        if (w) begin
            ref_mem[idx] = d;
            check({tag, "_mem"}, sram_mem[idx], d);
        end else begin
            exp_rd = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
        end
        check({tag, "_rdata"}, readData, exp_rd);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
        check({tag, "_err"}, {31'd0, addr_err}, 32'd0);
`endif
    endtask

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    task automatic issue_err(input logic w, input logic [31:0] a, input string tag);
        wr_en = w; rd_en = !w; address = a; writeData = 32'hFFFF_0000;
        #1;
        check({tag, "_rdy0"}, {31'd0, ready}, 32'd0);
        for (int i = 1; i <= W; i++) begin
            @(posedge CLK); #1;
            check({tag, "_we_n"}, {31'd0, we_n}, 32'd1);
            check({tag, "_acc_rdy"}, {31'd0, ready}, 32'd0);
        end
        @(posedge CLK); #1;
        check({tag, "_done_rdy"}, {31'd0, ready}, 32'd1);
        check({tag, "_err"}, {31'd0, addr_err}, 32'd1);
        check({tag, "_rdata"}, readData, exp_rd);
        finish_idle(tag);
    endtask
`endif

    initial begin
        int start_cyc;
        int unsigned idx;
        bit in_done;
        logic w, r;
        logic [31:0] a;

        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 32'd0;
        RST = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; writeData = 32'd0;
        exp_rd = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_we_n", {31'd0, we_n}, 32'd1);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rdata", readData, 32'd0);
        RST = 1'b0;

        issue(0, 1, 0, 32'd1024, 32'hDEADBEEF, "wr1024");
        finish_idle("wr1024");
        issue(0, 1, 0, 32'd1028, 32'h12345678, "wr1028");
        finish_idle("wr1028");
        issue(0, 0, 1, 32'd1028, 32'd0, "rd1028");
        check("rd1028_val", readData, 32'h12345678);
        finish_idle("rd1028");

        issue(0, 1, 1, 32'd1032, 32'hA5A5A5A5, "both1032");
        check("both1032_keep", readData, 32'h12345678);
        finish_idle("both1032");
        issue(0, 0, 1, 32'd1032, 32'd0, "rd1032");
        finish_idle("rd1032");

        // Read held through DONE, then a second read; DONE of the second lands 13 edges on.
        start_cyc = cyc;
        issue(0, 0, 1, 32'd1024, 32'd0, "b2b0");
        issue(1, 0, 1, 32'd1028, 32'd0, "b2b1");
        check("b2b_cycles", 32'(cyc - start_cyc), 32'(2 * (W + 1) + 1));
        finish_idle("b2b");

`ifndef SRAM_CTRL_ADDR_CHECK_EN
        issue(0, 1, 0, 32'd1024 + 32'd4 * 32'd131072, 32'h0BADF00D, "wrap");
        check("wrap_word0", sram_mem[0], 32'h0BADF00D);
        finish_idle("wrap");
        issue(0, 0, 1, 32'd1024, 32'd0, "rdwrap");
        check("rdwrap_val", readData, 32'h0BADF00D);
        finish_idle("rdwrap");
`else
        issue_err(1'b1, 32'd1000, "err1000");
        issue_err(1'b1, 32'd1026, "err1026");
        issue_err(1'b0, 32'd1000, "errrd1000");
        check("err_nowrite", sram_mem[word_idx(32'd1024)], ref_mem[word_idx(32'd1024)]);
`endif

        // Reset in the third access cycle of a write.
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; writeData = 32'hCAFEF00D;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        check("rstmid_we_n_before", {31'd0, we_n}, 32'd0);
        RST = 1'b1; wr_en = 1'b0;
        @(posedge CLK); #1;
        ref_mem[word_idx(32'd1040)] = 32'hCAFEF00D;
        exp_rd = 32'd0;
        check("rstmid_ready", {31'd0, ready}, 32'd1);
        check("rstmid_we_n", {31'd0, we_n}, 32'd1);
        check("rstmid_rdata", readData, 32'd0);
        check("rstmid_addr", 32'(sram_addr), 32'd0);
        RST = 1'b0;
        issue(0, 0, 1, 32'd1028, 32'd0, "rd_after_rst");
        check("rd_after_rst_val", readData, 32'h12345678);
        finish_idle("rd_after_rst");

        in_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (in_done && ($urandom_range(0, 1) == 0)) begin
                finish_idle("rnd");
                in_done = 1'b0;
            end
            case ($urandom_range(0, 2))
                0:       begin w = 1'b1; r = 1'b0; end
                1:       begin w = 1'b0; r = 1'b1; end
                default: begin w = 1'b1; r = 1'b1; end
            endcase
            a = BASE + 32'd4 * 32'($urandom_range(0, 15));
            issue(in_done, w, r, a, $urandom, "rnd");
            in_done = 1'b1;
        end
        finish_idle("rnd_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
